// File: rtl/vga_timing_core.sv
// Parametrised VGA raster engine: h/v counters, sync generation, pixel request and
// a PIPE-deep output pipeline that aligns external or test-pattern RGB with the syncs.
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 2,
  parameter int CW       = 10
) (
  input  logic          clk25,
  input  logic          reset,
  input  logic [1:0]    pattern_sel,
  input  logic [11:0]   rgb_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req,
  output logic [11:0]   rgb_out,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ZERO     = CW'(0);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_W    = CW'(H_ACTIVE / 8);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Sync flags are kept active-high inside the pipeline; polarity is applied at the pins.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ext;
    logic [11:0] pat;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  logic [CW-1:0] h_r;
  logic [CW-1:0] v_r;
  logic [1:0]    sel_r;
  logic [1:0]    sel_s;
  logic [CW-1:0] bar_s;
  stage_t        cur_s;
  stage_t        tap_s;

  function automatic logic [11:0] bar_colour(input logic [CW-1:0] idx);
    logic [11:0] c;
    if (idx > CW'(7)) begin
      c = 12'h000;
    end else begin
      case (idx[2:0])
        3'd0:    c = 12'hFFF;
        3'd1:    c = 12'hFF0;
        3'd2:    c = 12'h0FF;
        3'd3:    c = 12'h0F0;
        3'd4:    c = 12'hF0F;
        3'd5:    c = 12'hF00;
        3'd6:    c = 12'h00F;
        default: c = 12'h000;
      endcase
    end
    return c;
  endfunction

  assign x   = h_r;
  assign y   = v_r;
  assign req = cur_s.de;

  // Counter-domain view of the pixel; the selection is live on (0,0) so the new frame uses it.
  always_comb begin
    sel_s     = ((h_r == ZERO) && (v_r == ZERO)) ? pattern_sel : sel_r;
    bar_s     = h_r / BAR_W;
    cur_s     = stage_t'({STAGE_W{1'b0}});
    cur_s.de  = (h_r < H_ACT) && (v_r < V_ACT);
    cur_s.hs  = (h_r >= HS_START) && (h_r < HS_END);
    cur_s.vs  = (v_r >= VS_START) && (v_r < VS_END);
    cur_s.fs  = (h_r == ZERO) && (v_r == ZERO);
    case (sel_s)
      2'd0:    cur_s.ext = 1'b1;
      2'd1:    cur_s.pat = bar_colour(bar_s);
      2'd2:    cur_s.pat = (h_r[3] ^ v_r[3]) ? 12'hFFF : 12'h000;
      2'd3:    cur_s.pat = 12'h00F;
      default: cur_s.ext = 1'b1;
    endcase
  end

  // Raster counters and per-frame pattern latch.
  always_ff @(posedge clk25) begin
    if (reset) begin
      h_r   <= ZERO;
      v_r   <= ZERO;
      sel_r <= 2'd0;
    end else begin
      if ((h_r == ZERO) && (v_r == ZERO)) begin
        sel_r <= pattern_sel;
      end
      if (h_r == H_LAST) begin
        h_r <= ZERO;
        v_r <= (v_r == V_LAST) ? ZERO : v_r + ONE;
      end else begin
        h_r <= h_r + ONE;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_nodly
      assign tap_s = cur_s;
    end else begin : g_dly
      stage_t dly_r [PIPE];

      // Delay line matching the upstream source latency.
      always_ff @(posedge clk25) begin
        if (reset) begin
          for (int i = 0; i < PIPE; i++) begin
            dly_r[i] <= stage_t'({STAGE_W{1'b0}});
          end
        end else begin
          dly_r[0] <= cur_s;
          for (int i = 1; i < PIPE; i++) begin
            dly_r[i] <= dly_r[i-1];
          end
        end
      end

      assign tap_s = dly_r[PIPE-1];
    end
  endgenerate

  // Output register: rgb_in arrives in the same cycle as its delayed data-enable.
  always_ff @(posedge clk25) begin
    if (reset) begin
      rgb_out     <= 12'h000;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb_out     <= tap_s.de ? (tap_s.ext ? rgb_in : tap_s.pat) : 12'h000;
      hsync       <= tap_s.hs ? HS_ON : ~HS_ON;
      vsync       <= tap_s.vs ? VS_ON : ~VS_ON;
      de          <= tap_s.de;
      frame_start <= tap_s.fs;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised self-checking bench: two instances (short-frame default timing and an
// 800-wide active-high PIPE=0 variant) compared cycle by cycle against a raster model.
module tb_vga_timing_core;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 6,   AVF = 1,  AVS = 2,  AVB = 2;
  localparam int AP  = 2;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam int AFT = AHT * AVT;

  localparam int BHA = 800, BHF = 40, BHS = 128, BHB = 88;
  localparam int BVA = 6,   BVF = 1,  BVS = 4,   BVB = 3;
  localparam int BP  = 0;
  localparam int BHT = 1056;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam int BFT = BHT * BVT;

  logic        clk25 = 1'b0;
  logic        reset;
  logic [1:0]  pattern_sel;
  logic [11:0] rgb_in_a, rgb_in_b;

  logic [9:0]  x_a, y_a;
  logic        req_a, hsync_a, vsync_a, de_a, frame_start_a;
  logic [11:0] rgb_out_a;
  logic [10:0] x_b, y_b;
  logic        req_b, hsync_b, vsync_b, de_b, frame_start_b;
  logic [11:0] rgb_out_b;

  int          c;
  int          errors = 0;
  int          checks = 0;
  logic [11:0] gen [8];
  int          sel_a [16];
  int          sel_b [16];
  int          last_fs_a, de_cnt_a, vs_cnt_a, last_fs_b, last_hs_b;
  logic        hs_prev_b;

  always #5 clk25 = ~clk25;

  vga_timing_core #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HS_POL(0), .VS_POL(0), .PIPE(AP), .CW(10)
  ) u_dut_a (
    .clk25(clk25), .reset(reset), .pattern_sel(pattern_sel), .rgb_in(rgb_in_a),
    .x(x_a), .y(y_a), .req(req_a), .rgb_out(rgb_out_a), .hsync(hsync_a),
    .vsync(vsync_a), .de(de_a), .frame_start(frame_start_a)
  );

  vga_timing_core #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HS_POL(1), .VS_POL(1), .PIPE(BP), .CW(11)
  ) u_dut_b (
    .clk25(clk25), .reset(reset), .pattern_sel(pattern_sel), .rgb_in(rgb_in_b),
    .x(x_b), .y(y_b), .req(req_b), .rgb_out(rgb_out_b), .hsync(hsync_b),
    .vsync(vsync_b), .de(de_b), .frame_start(frame_start_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [11:0] bar_ref(input int idx);
    logic [11:0] r;
    case (idx)
      0:       r = 12'hFFF;
      1:       r = 12'hFF0;
      2:       r = 12'h0FF;
      3:       r = 12'h0F0;
      4:       r = 12'hF0F;
      5:       r = 12'hF00;
      6:       r = 12'h00F;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  // Expected {hsync, vsync, de, frame_start, rgb} for counter-domain cycle k of the run.
  function automatic logic [15:0] model_out(input int k, input int ha, hf, hsw, hb,
                                            input int va, vf, vsw, vb, input int sel,
                                            input logic [11:0] src, input logic hpol,
                                            input logic vpol);
    int ht, vt, h, v;
    logic on, hs, vs, fs;
    logic [11:0] rgb;
    if (k < 0) return {~hpol, ~vpol, 1'b0, 1'b0, 12'h000};
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    h   = k % ht;
    v   = (k / ht) % vt;
    on  = (h < ha) && (v < va);
    hs  = (h >= ha + hf) && (h < ha + hf + hsw);
    vs  = (v >= va + vf) && (v < va + vf + vsw);
    fs  = (k % (ht * vt)) == 0;
    rgb = 12'h000;
    if (on) begin
      case (sel)
        0:       rgb = src;
        1:       rgb = bar_ref(h / (ha / 8));
        2:       rgb = (((h / 8) + (v / 8)) % 2 == 1) ? 12'hFFF : 12'h000;
        3:       rgb = 12'h00F;
        default: rgb = src;
      endcase
    end
    return {hs ? hpol : ~hpol, vs ? vpol : ~vpol, on, fs, rgb};
  endfunction

  task automatic check_cycle();
    int k;
    logic [11:0] src;
    logic [15:0] exp;
    check_val("a_counters", {x_a, y_a, req_a},
              {10'(c % AHT), 10'((c / AHT) % AVT), 1'((c % AHT < AHA) && ((c / AHT) % AVT < AVA))});
    k   = c - AP - 1;
    src = (k >= 0) ? gen[k % 8] : 12'h000;
    exp = model_out(k, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB,
                    (k >= 0) ? sel_a[k / AFT] : 0, src, 1'b0, 1'b0);
    check_val("a_outputs", {hsync_a, vsync_a, de_a, frame_start_a, rgb_out_a}, 32'(exp));
    if (frame_start_a) begin
      if (last_fs_a < 0) begin
        check_val("a_first_frame_start", c, AP + 1);
      end else begin
        check_val("a_frame_period", c - last_fs_a, AFT);
        check_val("a_de_per_frame", de_cnt_a, AVA * AHA);
        check_val("a_vsync_cycles", vs_cnt_a, AVS * AHT);
      end
      last_fs_a = c;
      de_cnt_a  = 0;
      vs_cnt_a  = 0;
    end
    if (last_fs_a >= 0) begin
      de_cnt_a += int'(de_a);
      vs_cnt_a += int'(vsync_a == 1'b0);
    end

    check_val("b_counters", {x_b, y_b, req_b},
              {11'(c % BHT), 11'((c / BHT) % BVT), 1'((c % BHT < BHA) && ((c / BHT) % BVT < BVA))});
    k   = c - BP - 1;
    src = (k >= 0) ? gen[k % 8] : 12'h000;
    exp = model_out(k, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB,
                    (k >= 0) ? sel_b[k / BFT] : 0, src, 1'b1, 1'b1);
    check_val("b_outputs", {hsync_b, vsync_b, de_b, frame_start_b, rgb_out_b}, 32'(exp));
    if (hsync_b && !hs_prev_b) begin
      if (last_hs_b >= 0) check_val("b_h_total", c - last_hs_b, BHT);
      last_hs_b = c;
    end
    hs_prev_b = hsync_b;
    if (frame_start_b) begin
      if (last_fs_b < 0) check_val("b_first_frame_start", c, BP + 1);
      else               check_val("b_frame_period", c - last_fs_b, BFT);
      last_fs_b = c;
    end
  endtask

  task automatic drive_cycle();
    int pos;
    logic [31:0] r;
    pos = c % AFT;
    if (pos == AFT / 2) begin
      pattern_sel = 2'((c / AFT + 1) % 4);
    end else if (pos > 0 && pos < AFT / 2 && $urandom_range(0, 999) == 0) begin
      pattern_sel = 2'($urandom_range(0, 3));
    end
    if (c % AFT == 0) sel_a[c / AFT] = int'(pattern_sel);
    if (c % BFT == 0) sel_b[c / BFT] = int'(pattern_sel);
    r = $urandom;
    gen[c % 8] = r[11:0] | 12'h001;
    rgb_in_b   = gen[c % 8];
    rgb_in_a   = (c >= AP) ? gen[(c - AP) % 8] : r[23:12];
  endtask

  task automatic clear_run();
    c         = 0;
    last_fs_a = -1;
    de_cnt_a  = 0;
    vs_cnt_a  = 0;
    last_fs_b = -1;
    last_hs_b = -1;
    hs_prev_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel_a[i] = 0;
      sel_b[i] = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      check_cycle();
      drive_cycle();
      @(posedge clk25);
      #1;
      c++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    pattern_sel = 2'd0;
    rgb_in_a    = 12'h000;
    rgb_in_b    = 12'h000;
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b0;
    clear_run();
    run_cycles(2 * AFT + 3 * AHT + 300);

    // One-cycle reset in the middle of an active line.
    check_cycle();
    reset = 1'b1;
    @(posedge clk25);
    #1;
    reset = 1'b0;
    clear_run();
    run_cycles(3 * AFT + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
# vga_timing_core

Parametrised VGA raster engine: successor to the fixed 640x480 `vga` controller. Generates horizontal/vertical counters, sync pulses, data-enable and a pixel request for an upstream pixel source with configurable fetch latency. Emits sync-aligned 12-bit RGB from the external source or a built-in test pattern. Sits between the framebuffer/pixel generator and the board's VGA DAC pins, clocked by the 25 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- PIPE, 2, upstream latency in cycles from `req` to valid `rgb_in` (0..7)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports (one clock; reset is synchronous and active-high):
- clk25  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pattern_sel  in  2  0 external, 1 colour bars, 2 checkerboard, 3 solid blue
- rgb_in  in  12  {R[3:0],G[3:0],B[3:0]} from source, valid PIPE cycles after `req`
- x  out  CW  current horizontal counter (combinational from counter)
- y  out  CW  current vertical counter
- req  out  1  high when counters are in the active region
- rgb_out  out  12  pixel to DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, aligned with rgb_out
- frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525).
- h counts 0..H_TOTAL-1, wraps to 0; on wrap v increments, wraps to 0 after V_TOTAL-1.
- Active: h < H_ACTIVE and v < V_ACTIVE. `req` = active.
- hsync asserted (level HS_POL) for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, full lines (changes at h=0).
- Output stage: hsync/vsync/de/frame_start/pattern colour delayed through a PIPE-deep shift register, then one output register. rgb_in sampled at the same cycle its delayed `de` exits the shift register.
- rgb_out = 0 whenever de = 0, regardless of source.
- Patterns (computed on the x/y of the pixel being output):
  - bars: 8 bars of H_ACTIVE/8 px, left-to-right white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - checkerboard: x[3]^y[3] ? FFF : 000 (8x8 squares).
  - solid: 00F.
- pattern_sel sampled into a register only at h=0,v=0; mid-frame changes take effect next frame.
- Reset: h=v=0, shift register cleared (de=0, syncs inactive), rgb_out=0, hsync=~HS_POL, vsync=~VS_POL, de=0, frame_start=0, latched pattern = external (0). Reset mid-frame aborts the frame immediately; no partial sync pulse extends past reset.

## Timing
- x/y/req: combinational, same cycle as counter value.
- rgb_out/hsync/vsync/de/frame_start: latency PIPE+1 cycles from counter value.
- First cycle after reset deassert: counter at (0,0), req=1; de and frame_start high PIPE+1 cycles later.
- Frame period H_TOTAL*V_TOTAL = 420000 cycles (16.8 ms at 25 MHz default).
- Sync pulses and de relative alignment identical to counter-domain alignment (whole output delayed uniformly).

## Test plan
- Reset release, defaults, PIPE=2 -> de and frame_start rise cycle 3; de high 640 cycles, low 160; hsync low h=656..751 (output cycles 659..754 of the line).
- Run one full frame -> vsync low exactly 1600 cycles (lines 490-491), frame_start pulses again 420000 cycles after first; de count per frame = 307200.
- pattern_sel=0, rgb_in = x[7:0] replicated, PIPE=2 with modelled 2-cycle source -> rgb_out matches requested pixel; zero during blanking even if rgb_in nonzero.
- pattern_sel switched 0->1 at mid-frame -> output stays external until next frame_start, then bars FFF for pixels 0..79, FF0 80..159, ... 000 560..639.
- Assert reset for 1 cycle mid-line in active region -> next cycle de=0, rgb_out=0, syncs inactive, x=y=0; frame restarts cleanly.
- Re-parametrise HS_POL=1, VS_POL=1, PIPE=0, 800x600-style timings (40/128/88, 1/4/23) -> syncs active-high, latency 1 cycle, H_TOTAL 1056, V_TOTAL 628 confirmed.
